// File: rtl/imem_ctrl_pkg.sv
// Shared definitions for the instruction-memory controller slice.
// No logic; pure types and constants.
// No flow control.
`timescale 1ns/1ps
package imem_ctrl_pkg;

    localparam int IMEM_AW_DEFAULT = 12;
    localparam int IMEM_SIZE       = 1 << IMEM_AW_DEFAULT;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    function automatic logic misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/imem_ctrl_if.sv
// Bundle of fetch, loader and memory-port signals around imem_ctrl.
// Wiring only, no latency.
// Loader uses ld_valid/ld_ready; fetch stalls via if_stall.
`timescale 1ns/1ps
interface imem_ctrl_if
    import imem_ctrl_pkg::*;
#(
    parameter int AW = IMEM_AW_DEFAULT
);
    logic          if_req;
    logic [31:0]   if_addr;
    logic [31:0]   if_rdata;
    logic          if_valid;
    logic          if_stall;
    logic          if_fault;
    logic          ld_start;
    logic          ld_valid;
    logic [7:0]    ld_byte;
    logic          ld_ready;
    logic          ld_end;
    logic [AW-1:0] ld_count;
    logic          cpu_hold;
    logic [AW-3:0] mem_addr;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr, ld_start, ld_valid, ld_byte, ld_end, mem_rdata,
        output if_rdata, if_valid, if_stall, if_fault, ld_ready, ld_count,
               cpu_hold, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output if_req, if_addr, ld_start, ld_valid, ld_byte, ld_end, mem_rdata,
        input  if_rdata, if_valid, if_stall, if_fault, ld_ready, ld_count,
               cpu_hold, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/imem_word_packer.sv
// Packs loader bytes little-endian into 32-bit words, zero-padding partial words.
// Write strobe/data registered: one cycle after the 4th byte or the flush request.
// Never backpressures; accepts one byte per cycle.
`timescale 1ns/1ps
module imem_word_packer
    import imem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        accept,
    input  logic        flush,
    input  logic [7:0]  byte_in,
    output logic        idx_next_zero,
    output logic        we,
    output logic [31:0] wdata
);
    logic [1:0]  idx_q, idx_d, idx_inc;
    logic [31:0] buf_q, buf_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;

    always_comb begin
        idx_inc       = idx_q + 2'd1;
        idx_next_zero = accept ? (idx_inc == 2'd0) : (idx_q == 2'd0);
        buf_d         = buf_q;
        idx_d         = idx_q;
        we_d          = 1'b0;
        wdata_d       = wdata_q;
        if (clr) begin
            buf_d = '0;
            idx_d = '0;
        end else begin
            if (accept) begin
                buf_d[{idx_q, 3'b000} +: 8] = byte_in;
                idx_d = idx_inc;
            end
            // Clearing the buffer after every write keeps unfilled lanes zero.
            if ((accept && idx_q == 2'd3) || flush) begin
                we_d    = 1'b1;
                wdata_d = buf_d;
                buf_d   = '0;
                idx_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q   <= '0;
            buf_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    assign we    = we_q;
    assign wdata = wdata_q;
endmodule

// File: rtl/imem_ctrl.sv
// Shares the instruction-memory port between IF fetches (RUN) and a byte loader (LOAD/FLUSH).
// Fetch data registered, 1-cycle latency, back-to-back; word writes 1 cycle after 4th byte.
// if_stall and cpu_hold assert while loading or a write is pending; ld_ready never drops in LOAD.
`timescale 1ns/1ps
module imem_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int IMEM_ADDR_WIDTH = IMEM_AW_DEFAULT
)(
    input  logic        clk,
    input  logic        rst,
    imem_ctrl_if.slave  bus
);
    state_t                     state_q, state_d;
    logic [IMEM_ADDR_WIDTH-3:0] wptr_q, wptr_d;
    logic [IMEM_ADDR_WIDTH-1:0] ld_count_q, ld_count_d;
    logic [31:0]                if_rdata_q, if_rdata_d;
    logic                       if_valid_q, if_valid_d;
    logic                       if_fault_q, if_fault_d;

    logic ld_ready, cpu_hold, if_stall;
    logic ld_start_go, accept, go_flush, fetch_go;
    logic pk_idx_zero, pk_we;
    logic [31:0] pk_wdata;
    logic unused_addr_hi;

    assign unused_addr_hi = ^bus.if_addr[31:IMEM_ADDR_WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_RUN;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (bus.ld_start) state_d = ST_LOAD;
            // pk_idx_zero already accounts for a byte accepted alongside ld_end.
            ST_LOAD:  if (bus.ld_end) state_d = pk_idx_zero ? ST_RUN : ST_FLUSH;
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        ld_ready = (state_q == ST_LOAD);
        cpu_hold = (state_q != ST_RUN) || pk_we;
        if_stall = bus.if_req && cpu_hold;
    end

    always_comb begin
        ld_start_go = (state_q == ST_RUN) && bus.ld_start;
        accept      = bus.ld_valid && ld_ready;
        go_flush    = (state_q == ST_LOAD) && bus.ld_end && !pk_idx_zero;
        fetch_go    = bus.if_req && !cpu_hold;

        wptr_d = wptr_q;
        if (ld_start_go) wptr_d = '0;
        else if (pk_we)  wptr_d = wptr_q + 1'b1;

        ld_count_d = ld_count_q;
        if (ld_start_go) ld_count_d = '0;
        else if (accept) ld_count_d = ld_count_q + 1'b1;

        if_rdata_d = if_rdata_q;
        if_valid_d = fetch_go;
        if_fault_d = 1'b0;
        if (fetch_go) begin
            if_rdata_d = bus.mem_rdata;
            if_fault_d = misaligned(bus.if_addr);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            ld_count_q <= '0;
            if_rdata_q <= '0;
            if_valid_q <= 1'b0;
            if_fault_q <= 1'b0;
        end else begin
            wptr_q     <= wptr_d;
            ld_count_q <= ld_count_d;
            if_rdata_q <= if_rdata_d;
            if_valid_q <= if_valid_d;
            if_fault_q <= if_fault_d;
        end
    end

    imem_word_packer u_packer (
        .clk           (clk),
        .rst           (rst),
        .clr           (ld_start_go),
        .accept        (accept),
        .flush         (go_flush),
        .byte_in       (bus.ld_byte),
        .idx_next_zero (pk_idx_zero),
        .we            (pk_we),
        .wdata         (pk_wdata)
    );

    assign bus.mem_addr  = pk_we ? wptr_q : bus.if_addr[IMEM_ADDR_WIDTH-1:2];
    assign bus.mem_we    = pk_we;
    assign bus.mem_wdata = pk_wdata;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_fault  = if_fault_q;
    assign bus.if_stall  = if_stall;
    assign bus.ld_ready  = ld_ready;
    assign bus.ld_count  = ld_count_q;
    assign bus.cpu_hold  = cpu_hold;
endmodule

// File: tb/tb_imem_ctrl.sv
// Directed + randomized bench for imem_ctrl with a memory array and a word-level reference.
`timescale 1ns/1ps
module tb_imem_ctrl;
    import imem_ctrl_pkg::*;

    localparam int AW = 12;
    localparam int NW = 1 << (AW - 2);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_ctrl_if #(.AW(AW)) bus();
    imem_ctrl #(.IMEM_ADDR_WIDTH(AW)) dut (.clk(clk), .rst(rst_n), .bus(bus));

    logic [31:0]   mem [0:NW-1];
    logic          pre_we = 1'b0;
    logic [AW-3:0] pre_a = '0;
    logic [31:0]   pre_d = '0;
    logic [AW-3:0] wr_a [$];
    logic [31:0]   wr_d [$];

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            wr_a.push_back(bus.mem_addr);
            wr_d.push_back(bus.mem_wdata);
        end else if (pre_we) begin
            mem[pre_a] <= pre_d;
        end
    end

    int checks = 0;
    int errors = 0;
    logic [31:0] ref_mem [0:NW-1];
    logic [7:0]  stim [$];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Loads stim[0..n-1]; expected words come from plain byte arithmetic.
    task automatic run_load(input int n, input bit with_fetch, input bit probe);
        logic [31:0] exp_a [$];
        logic [31:0] exp_d [$];
        logic [31:0] f_exp, word;
        int nw, m;
        f_exp = ref_mem[0];
        nw = (n + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            word = 32'd0;
            for (int b = 0; b < 4; b++)
                if (4 * w + b < n) word = word | ({24'd0, stim[4 * w + b]} << (8 * b));
            exp_a.push_back(32'(w % NW));
            exp_d.push_back(word);
            ref_mem[w % NW] = word;
        end
        wr_a.delete();
        wr_d.delete();
        bus.ld_start = 1'b1;
        if (with_fetch) begin
            bus.if_req  = 1'b1;
            bus.if_addr = 32'h0;
        end
        #1 chk("hold_before_start", bus.cpu_hold, 0);
        tick();
        bus.ld_start = 1'b0;
        bus.if_req   = 1'b0;
        if (with_fetch) begin
            chk("fetch_at_start_vld", bus.if_valid, 1);
            chk("fetch_at_start_dat", bus.if_rdata, f_exp);
        end
        #1;
        chk("hold_in_load", bus.cpu_hold, 1);
        chk("ready_in_load", bus.ld_ready, 1);
        for (int i = 0; i < n; i++) begin
            if (i > 0 && $urandom_range(0, 3) == 0) begin
                bus.ld_valid = 1'b0;
                tick();
            end
            bus.ld_valid = 1'b1;
            bus.ld_byte  = stim[i];
            bus.ld_end   = (i == n - 1);
            if (probe && i == 0) begin
                bus.if_req  = 1'b1;
                bus.if_addr = 32'h4;
                #1 chk("stall_in_load", bus.if_stall, 1);
            end
            if (probe && i == 2) bus.ld_start = 1'b1;
            tick();
            bus.ld_start = 1'b0;
            if (probe && i == 0) begin
                chk("no_fetch_in_load", bus.if_valid, 0);
                bus.if_req = 1'b0;
            end
        end
        bus.ld_valid = 1'b0;
        bus.ld_end   = 1'b0;
        for (int k = 0; k < 8 && bus.cpu_hold === 1'b1; k++) tick();
        chk("hold_fall", bus.cpu_hold, 0);
        chk("ready_after_load", bus.ld_ready, 0);
        chk("ld_count", 32'(bus.ld_count), 32'(n % (1 << AW)));
        chk("write_count", wr_a.size(), exp_a.size());
        m = (wr_a.size() < exp_a.size()) ? wr_a.size() : exp_a.size();
        for (int j = 0; j < m; j++) begin
            chk("write_addr", 32'(wr_a[j]), exp_a[j]);
            chk("write_data", wr_d[j], exp_d[j]);
        end
    endtask

    initial begin
        logic [31:0] a;
        int w;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.ld_start = 1'b0;
        bus.ld_valid = 1'b0; bus.ld_byte = '0; bus.ld_end = 1'b0;

        pre_we = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pre_a = AW'(i) >> 0;
            pre_d = $urandom();
            ref_mem[i] = pre_d;
            tick();
        end
        pre_we = 1'b0;
        chk("rst_if_rdata", bus.if_rdata, 0);
        chk("rst_if_valid", bus.if_valid, 0);
        chk("rst_if_fault", bus.if_fault, 0);
        chk("rst_ld_count", 32'(bus.ld_count), 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_cpu_hold", bus.cpu_hold, 0);
        chk("rst_ld_ready", bus.ld_ready, 0);
        chk("rst_if_stall", bus.if_stall, 0);
        rst_n = 1'b1;
        tick();

        // back-to-back aligned fetches
        bus.if_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.if_addr = 32'(4 * i);
            tick();
            chk("b2b_valid", bus.if_valid, 1);
            chk("b2b_data", bus.if_rdata, ref_mem[i]);
            chk("b2b_fault", bus.if_fault, 0);
        end
        bus.if_addr = 32'h6;
        tick();
        chk("misalign_fault", bus.if_fault, 1);
        chk("misalign_valid", bus.if_valid, 1);
        chk("misalign_data", bus.if_rdata, ref_mem[1]);
        bus.if_req = 1'b0;
        tick();
        chk("idle_valid", bus.if_valid, 0);

        stim = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(8, 1'b0, 1'b1);
        bus.if_req = 1'b1; bus.if_addr = 32'h4;
        tick();
        bus.if_req = 1'b0;
        chk("fetch_deadbeef", bus.if_rdata, 32'hDEADBEEF);

        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_load(6, 1'b1, 1'b0);
        bus.if_req = 1'b1; bus.if_addr = 32'h4;
        tick();
        bus.if_req = 1'b0;
        chk("fetch_flushed", bus.if_rdata, 32'h00000605);

        // ld_end while running has no effect
        bus.ld_end = 1'b1; bus.ld_valid = 1'b1;
        #1 chk("run_ready", bus.ld_ready, 0);
        tick();
        bus.ld_end = 1'b0; bus.ld_valid = 1'b0;
        chk("run_end_hold", bus.cpu_hold, 0);
        chk("run_end_count", 32'(bus.ld_count), 6);

        for (int r = 0; r < 6; r++) begin
            stim.delete();
            w = $urandom_range(1, 40);
            for (int i = 0; i < w; i++) stim.push_back(8'($urandom()));
            run_load(w, r[0], 1'b0);
        end

        // random back-to-back fetches from words 0..9 (always defined)
        bus.if_req = 1'b1;
        for (int j = 0; j < 16; j++) begin
            a = {20'd0, 8'($urandom_range(0, 9)), 2'b00, 2'b00};
            a = {24'd0, 6'(a[5:2] >> 0), 2'b00};
            a = 32'($urandom_range(0, 9)) * 4;
            if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
            bus.if_addr = a;
            tick();
            chk("rnd_valid", bus.if_valid, 1);
            chk("rnd_data", bus.if_rdata, ref_mem[a[AW-1:2]]);
            chk("rnd_fault", bus.if_fault, 32'(a[1:0] != 2'b00));
        end
        bus.if_req = 1'b0;

        // 1025 words: the last wraps onto index 0
        stim.delete();
        for (int i = 0; i < 4 * (NW + 1); i++) stim.push_back(8'($urandom()));
        run_load(4 * (NW + 1), 1'b0, 1'b0);
        chk("wrap_last_addr", (wr_a.size() == NW + 1) ? 32'(wr_a[NW]) : 32'hFFFF_FFFF, 0);
        bus.if_req = 1'b1; bus.if_addr = 32'h0;
        tick();
        bus.if_req = 1'b0;
        chk("wrap_fetch0", bus.if_rdata, {stim[4*NW+3], stim[4*NW+2], stim[4*NW+1], stim[4*NW]});

        // reset in the middle of a word
        wr_a.delete(); wr_d.delete();
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_byte  = 8'($urandom());
            tick();
        end
        bus.ld_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_if_rdata", bus.if_rdata, 0);
        chk("mid_rst_if_valid", bus.if_valid, 0);
        chk("mid_rst_if_fault", bus.if_fault, 0);
        chk("mid_rst_ld_count", 32'(bus.ld_count), 0);
        chk("mid_rst_mem_we", bus.mem_we, 0);
        chk("mid_rst_mem_wdata", bus.mem_wdata, 0);
        chk("mid_rst_cpu_hold", bus.cpu_hold, 0);
        chk("mid_rst_ld_ready", bus.ld_ready, 0);
        chk("mid_rst_if_stall", bus.if_stall, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("mid_rst_no_write", wr_a.size(), 0);
        chk("mid_rst_run_hold", bus.cpu_hold, 0);
        chk("mid_rst_run_ready", bus.ld_ready, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
